fa4_share_ctrl: RTL and testbench

FA4_SHARE_CTRL -- requirements
Module: fa4_share_ctrl

---
 rtl/fa4_share_ctrl.sv | 112 +++++++++++
 tb/tb_fa4_share_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fa4_share_ctrl.sv
// rtl/fa4_share_ctrl.sv - two-requester arbiter sharing one 4-bit full-adder nibble datapath
// Operands are added LSB nibble first over NIB cycles; the result is published on DONE entry.
module fa4_share_ctrl #(
  parameter int NIB = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [4*NIB-1:0]  a0,
  input  logic [4*NIB-1:0]  b0,
  input  logic              ci0,
  input  logic              req1,
  input  logic [4*NIB-1:0]  a1,
  input  logic [4*NIB-1:0]  b1,
  input  logic              ci1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [4*NIB-1:0]  s,
  output logic              co
);

  localparam int W  = 4 * NIB;
  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic            ptr;
  logic [CW-1:0]   cnt;
  logic            carry;
  logic            id_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    acc;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [4:0]      nib_sum;
  logic [W-1:0]    acc_nx;
  logic            last;

  // ptr=0 prefers requester 0 when both request; a lone request always wins.
  assign gnt0 = (state == IDLE) && req0 && (!req1 || !ptr);
  assign gnt1 = (state == IDLE) && req1 && (!req0 || ptr);
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign last = (cnt == CW'(NIB - 1));

  always_comb begin
    a_nib  = 4'd0;
    b_nib  = 4'd0;
    acc_nx = acc;
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
    nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'd0, carry};
    for (int i = 0; i < NIB; i++) begin
      if (cnt == CW'(i)) acc_nx[4*i +: 4] = nib_sum[3:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= 1'b0;
      cnt     <= '0;
      carry   <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      s       <= '0;
      co      <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            id_q  <= gnt1;
            a_q   <= gnt1 ? a1 : a0;
            b_q   <= gnt1 ? b1 : b0;
            carry <= gnt1 ? ci1 : ci0;
            cnt   <= '0;
            acc   <= '0;
            ptr   <= gnt0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          carry <= nib_sum[4];
          cnt   <= cnt + 1'b1;
          if (last) begin
            s       <= acc_nx;
            co      <= nib_sum[4];
            done_id <= id_q;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa4_share_ctrl.sv
// tb/tb_fa4_share_ctrl.sv - directed self-checking bench for fa4_share_ctrl (NIB=4)
module tb_fa4_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, ci0, ci1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id, co;
  logic [15:0] s;

  int pass_cnt = 0;
  int total    = 0;

  fa4_share_ctrl #(.NIB(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .ci0(ci0),
    .req1(req1), .a1(a1), .b1(b1), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .s(s), .co(co)
  );

  always #5 clk = ~clk;

  // Issues one request at a negedge, scrambles operands after the grant,
  // and returns the latency (grant cycle = 0) and the published result.
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic ci,
                       output bit gnt_ok, output int lat,
                       output logic [15:0] rs, output logic rco, output logic rid);
    @(negedge clk);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; ci1 = ci; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; ci0 = ci; end
    #1;
    gnt_ok = id ? (gnt1 && !gnt0) : (gnt0 && !gnt1);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a; b0 = ~b; a1 = ~a; b1 = ~b; ci0 = ~ci; ci1 = ~ci;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rs = s; rco = co; rid = done_id;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; ci0 = 0; ci1 = 0;
    #1;
    total++;
    if ({gnt0, gnt1, busy, done, done_id, co} !== 6'b0 || s !== 16'h0)
      $display("FAIL reset_outputs got gnt=%b%b busy=%b done=%b id=%b s=%h co=%b want all 0",
               gnt0, gnt1, busy, done, done_id, s, co);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    bit g; int lat; logic [15:0] rs; logic rco, rid;
    do_op(1'b0, 16'h1234, 16'h1111, 1'b0, g, lat, rs, rco, rid);
    total++;
    if (!g) $display("FAIL basic_gnt got 0 want gnt0 only"); else pass_cnt++;
    total++;
    if (lat !== 5) $display("FAIL basic_latency got %0d want 5", lat); else pass_cnt++;
    total++;
    if ({rco, rs, rid} !== {1'b0, 16'h2345, 1'b0})
      $display("FAIL basic_result got co=%b s=%h id=%b want co=0 s=2345 id=0", rco, rs, rid);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== 16'h2345)
      $display("FAIL basic_hold got done=%b busy=%b s=%h want 0 0 2345", done, busy, s);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    bit g; int lat; logic [15:0] rs; logic rco, rid;
    do_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, g, lat, rs, rco, rid);
    total++;
    if (!g || lat !== 5) $display("FAIL ovf_gnt_lat got gnt_ok=%0d lat=%0d want 1 5", g, lat); else pass_cnt++;
    total++;
    if ({rco, rs, rid} !== {1'b1, 16'h0000, 1'b1})
      $display("FAIL ovf_result got co=%b s=%h id=%b want co=1 s=0000 id=1", rco, rs, rid);
    else pass_cnt++;
  endtask

  task automatic test_ripple();
    bit g; int lat; logic [15:0] rs; logic rco, rid;
    do_op(1'b1, 16'h0000, 16'hFFFF, 1'b1, g, lat, rs, rco, rid);
    total++;
    if ({rco, rs, rid} !== {1'b1, 16'h0000, 1'b1})
      $display("FAIL ripple_result got co=%b s=%h id=%b want co=1 s=0000 id=1", rco, rs, rid);
    else pass_cnt++;
    do_op(1'b0, 16'h8000, 16'h7FFF, 1'b1, g, lat, rs, rco, rid);
    total++;
    if ({rco, rs, rid} !== {1'b1, 16'h0000, 1'b0})
      $display("FAIL ripple2_result got co=%b s=%h id=%b want co=1 s=0000 id=0", rco, rs, rid);
    else pass_cnt++;
    do_op(1'b0, 16'hA5C3, 16'h1E2F, 1'b0, g, lat, rs, rco, rid);
    total++;
    if ({rco, rs} !== {1'b0, 16'hC3F2})
      $display("FAIL mixed_result got co=%b s=%h want co=0 s=c3f2", rco, rs);
    else pass_cnt++;
  endtask

  task automatic test_round_robin();
    int gcyc[4]; bit gid[4]; bit did[4]; logic [15:0] ds[4];
    int ng = 0; int nd = 0; bit both = 0;
    apply_reset();
    @(negedge clk);
    req0 = 1; a0 = 16'h0001; b0 = 16'h0002; ci0 = 0;
    req1 = 1; a1 = 16'h0010; b1 = 16'h0020; ci1 = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (gnt0 && gnt1) both = 1;
      if ((gnt0 || gnt1) && ng < 4) begin gcyc[ng] = c; gid[ng] = gnt1; ng++; end
      if (done && nd < 4) begin did[nd] = done_id; ds[nd] = s; nd++; end
      @(negedge clk);
    end
    req0 = 0; req1 = 0;
    total++;
    if (both) $display("FAIL rr_exclusive got both grants high want never"); else pass_cnt++;
    total++;
    if (ng !== 4 || nd !== 4) $display("FAIL rr_counts got grants=%0d dones=%0d want 4 4", ng, nd);
    else pass_cnt++;
    if (ng == 4 && nd == 4) begin
      total++;
      if ({gid[0], gid[1], gid[2], gid[3]} !== 4'b0101 || {did[0], did[1], did[2], did[3]} !== 4'b0101)
        $display("FAIL rr_order got gnt=%b%b%b%b done_id=%b%b%b%b want 0101 0101",
                 gid[0], gid[1], gid[2], gid[3], did[0], did[1], did[2], did[3]);
      else pass_cnt++;
      total++;
      if (gcyc[1] - gcyc[0] != 6 || gcyc[2] - gcyc[1] != 6 || gcyc[3] - gcyc[2] != 6)
        $display("FAIL rr_spacing got %0d %0d %0d want 6 6 6",
                 gcyc[1] - gcyc[0], gcyc[2] - gcyc[1], gcyc[3] - gcyc[2]);
      else pass_cnt++;
      total++;
      if (ds[0] !== 16'h0003 || ds[1] !== 16'h0030)
        $display("FAIL rr_results got %h %h want 0003 0030", ds[0], ds[1]);
      else pass_cnt++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    bit g; int lat; logic [15:0] rs; logic rco, rid; bit saw_done = 0;
    @(negedge clk);
    req0 = 1; a0 = 16'h0F0F; b0 = 16'h0F0F; ci0 = 0;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (busy !== 0 || done !== 0 || s !== 16'h0 || co !== 0)
      $display("FAIL midrun_reset got busy=%b done=%b s=%h co=%b want 0 0 0000 0", busy, done, s, co);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (done) saw_done = 1;
      @(negedge clk);
    end
    total++;
    if (saw_done) $display("FAIL midrun_no_done got done pulse want none"); else pass_cnt++;
    do_op(1'b0, 16'h0001, 16'h0001, 1'b0, g, lat, rs, rco, rid);
    total++;
    if (!g || lat !== 5 || rs !== 16'h0002 || rco !== 0)
      $display("FAIL midrun_recover got gnt_ok=%0d lat=%0d s=%h co=%b want 1 5 0002 0", g, lat, rs, rco);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    bit early = 0; bit g0; int lat = 0;
    @(negedge clk);
    req0 = 1; a0 = 16'h4321; b0 = 16'h1000; ci0 = 1;
    #1;
    g0 = gnt0 && !gnt1;
    @(negedge clk);
    req0 = 0; req1 = 1; a1 = 16'h00FF; b1 = 16'h0F01; ci1 = 0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (gnt0 || gnt1) early = 1;
      if (c == 5) begin
        total++;
        if (done !== 1 || s !== 16'h5322 || done_id !== 0)
          $display("FAIL busy_first_result got done=%b s=%h id=%b want 1 5322 0", done, s, done_id);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    #1;
    total++;
    if (!g0 || early || gnt1 !== 1 || gnt0 !== 0)
      $display("FAIL busy_ignore got g0=%0d early=%0d gnt1=%b want 1 0 1", g0, early, gnt1);
    else pass_cnt++;
    @(negedge clk);
    req1 = 0;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    total++;
    if (done !== 1 || s !== 16'h1000 || co !== 0 || done_id !== 1)
      $display("FAIL busy_second_result got done=%b s=%h co=%b id=%b want 1 1000 0 1", done, s, co, done_id);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ripple();
    test_round_robin();
    test_reset_mid_run();
    test_busy_ignore();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
